demux4_buf: RTL

Buffered 1-to-4 demultiplexer: the write-side counterpart of the 4-input datapath select mux. It accepts one word per cycle on a valid/ready input with a 2-bit destination select and steers the word into one of four output lanes. Each lane holds one word in a register until its consumer takes it. Used wherever a single MIPS datapath result must be delivered to one of four sinks that may stall independently, such as the memory-mapped write path.

---
 rtl/demux4_buf.sv | 87 ++++++++
 1 files changed

// File: rtl/demux4_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready input steered into four single-entry output lanes.
// Optional per-lane accept counters (stat_cnt0..3) are built when DEMUX4_STATS_EN is defined.
module demux4_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
`ifdef DEMUX4_STATS_EN
  ,
  output logic [7:0]       stat_cnt0,
  output logic [7:0]       stat_cnt1,
  output logic [7:0]       stat_cnt2,
  output logic [7:0]       stat_cnt3
`endif
);

  logic             accept_p0;
  logic [3:0]       load_p0;
  logic [3:0]       drain_p0;
  logic [3:0]       vld_p1;
  logic [WIDTH-1:0] data_p1 [4];

  // Stage 0: select-lane handshake; a draining lane can be reloaded in the same cycle
  always_comb begin
    in_ready          = ~vld_p1[in_sel] | out_ready[in_sel];
    accept_p0         = in_valid & in_ready;
    load_p0           = '0;
    load_p0[in_sel]   = accept_p0;
    drain_p0          = vld_p1 & out_ready;
  end

  // Stage 1: lane registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= '0;
    end else begin
      vld_p1 <= load_p0 | (vld_p1 & ~drain_p0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) data_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_p0[i]) data_p1[i] <= in_data;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data0 = data_p1[0];
  assign out_data1 = data_p1[1];
  assign out_data2 = data_p1[2];
  assign out_data3 = data_p1[3];

`ifdef DEMUX4_STATS_EN
  logic [7:0] cnt_p1 [4];

  // Stage 1: accept counters, wrapping naturally at 8 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_p0[i]) cnt_p1[i] <= cnt_p1[i] + 8'd1;
      end
    end
  end

  assign stat_cnt0 = cnt_p1[0];
  assign stat_cnt1 = cnt_p1[1];
  assign stat_cnt2 = cnt_p1[2];
  assign stat_cnt3 = cnt_p1[3];
`endif

endmodule
